// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Per-register scoreboard of countdown timers for an in-order pipeline.
//   A writing instruction that issues from ID loads the timer of its
//   destination register; ID is frozen while any source operand it
//   actually reads still has a nonzero timer.
//
// Parameters
//   REG_W      register-address width (2**REG_W scoreboard entries)
//   NUM_SRC    source operands checked per instruction
//   WB_DELAY   cycles a result is unreadable when forwarding is off
//   LOAD_DELAY cycles a load result is unforwardable (load-use)
//
// Ports
//   clk           pipeline clock
//   rst           asynchronous reset, active-low
//   forwardingEn  1 = forwarding datapath active (sampled at issue only)
//   id_valid      ID holds a real instruction
//   src           packed source addresses, operand i at [i*REG_W +: REG_W]
//   src_use       bit i = operand i is read
//   id_wbEn       ID instruction writes a register
//   id_memReadEn  ID instruction is a load
//   id_wbDst      destination register of the ID instruction
//   pipe_hold     whole pipeline stalled; nothing advances
//   freeze        stall ID/IF, inject bubble into EXE
//   busy_mask     bit r = scoreboard entry r nonzero
//   stall_cycles  (only with HAZARD_STATS_EN) saturating count of cycles
//                 with freeze=1 and pipe_hold=0
//
// Optional feature macro: HAZARD_STATS_EN

module hazard_scoreboard_unit #(
    parameter int REG_W      = 4,
    parameter int NUM_SRC    = 3,
    parameter int WB_DELAY   = 2,
    parameter int LOAD_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forwardingEn,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] src,
    input  logic [NUM_SRC-1:0]       src_use,
    input  logic                     id_wbEn,
    input  logic                     id_memReadEn,
    input  logic [REG_W-1:0]         id_wbDst,
    input  logic                     pipe_hold,
    output logic                     freeze,
`ifdef HAZARD_STATS_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic [(2**REG_W)-1:0]    busy_mask
);

    localparam int NUM_REG   = 2**REG_W;
    localparam int MAX_DELAY = (WB_DELAY > LOAD_DELAY) ? WB_DELAY : LOAD_DELAY;
    // Keep at least one bit even if both delays are zero.
    localparam int CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

    localparam logic [CNT_W-1:0] WB_CNT   = CNT_W'(WB_DELAY);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_DELAY);

    logic [CNT_W-1:0] cnt [NUM_REG];
    logic             src_pending;
    logic             issue;
    logic [CNT_W-1:0] issue_cnt;

    // Hazard check uses only registered state, so a same-instruction
    // src==dst never sees its own write.
    always_comb begin
        src_pending = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_use[i] && (cnt[src[i*REG_W +: REG_W]] != '0)) begin
                src_pending = 1'b1;
            end
        end
    end

    assign freeze = id_valid && src_pending;
    assign issue  = id_valid && !freeze && !pipe_hold;

    // Forwarded non-load results are available immediately; loads still
    // need LOAD_DELAY cycles. Without forwarding everything waits for WB.
    always_comb begin
        issue_cnt = WB_CNT;
        if (forwardingEn) begin
            issue_cnt = id_memReadEn ? LOAD_CNT : '0;
        end
    end

    // A new issue overwrites rather than maxes: the younger writer is the
    // one a later reader must wait for.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REG; r++) begin
                if (issue && id_wbEn && (id_wbDst == REG_W'(r))) begin
                    cnt[r] <= issue_cnt;
                end else if (pipe_hold) begin
                    cnt[r] <= cnt[r];
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (freeze && !pipe_hold && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
